slv_guard_rst_ctrl: RTL and testbench
=====================================

SLV_GUARD_RST_CTRL -- requirements
Module: slv_guard_rst_ctrl

Interface
REQ-001 SHALL have parameter AssertCycles, default 16: number of cycles slv_rst_o is held high per event; legal range is 1 or more.
REQ-002 SHALL have parameter SettleCycles, default 4: post-release settle cycles before acknowledging; legal range is 0 or more.
REQ-003 SHALL have parameter AckTimeout, default 8: cycles in ACK with rst_req_i still high before err_o is set; legal range is 1 or more.
REQ-004 SHALL have parameter EvtCntWidth, default 8: width of the reset-event counter.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port rst_req_i, input, 1 bit: level reset request from the guard's rst_req_o.
REQ-008 SHALL have port slv_rst_o, output, 1 bit: active-high reset to the guarded subordinate.
REQ-009 SHALL have port rst_stat_o, output, 1 bit: reset-complete acknowledge, wired to the guard's rst_stat_i.
REQ-010 SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-011 SHALL have port err_o, output, 1 bit: sticky acknowledge-timeout flag.
REQ-012 SHALL have port err_clr_i, input, 1 bit: clears err_o.
REQ-013 SHALL have port evt_cnt_o, output, EvtCntWidth bits: saturating count of reset events.

Function
REQ-014 SHALL implement a four-phase req/ack handshake with the FSM states IDLE, ASSERT, SETTLE, ACK.
REQ-015 SHALL register all outputs; no output is combinational from any input.
REQ-016 SHALL transition from IDLE to ASSERT on the first edge at which rst_req_i is sampled 1; slv_rst_o and busy_o are 1 starting the next cycle.
REQ-017 SHALL hold slv_rst_o at 1 for exactly AssertCycles consecutive cycles, then drive it to 0 and enter SETTLE, or enter ACK directly when SettleCycles is 0.
REQ-018 SHALL remain in SETTLE for exactly SettleCycles cycles with slv_rst_o at 0, then enter ACK.
REQ-019 SHALL drive rst_stat_o to 1 in every ACK cycle and keep it 0 in all other states; ACK lasts at least 1 cycle.
REQ-020 SHALL transition from ACK to IDLE on the first edge at which rst_req_i is sampled 0; rst_stat_o and busy_o are 0 the following cycle.
REQ-021 SHALL ignore rst_req_i during ASSERT and SETTLE: a request dropped mid-sequence does not shorten it, and a held request does not restart it.
REQ-022 SHALL require one IDLE cycle between events; IDLE is re-exited only on a fresh sample of rst_req_i equal to 1.
REQ-023 SHALL use an internal down-counter wide enough for max(AssertCycles, SettleCycles, AckTimeout); the counter is loaded on each state entry and never wraps.
REQ-024 SHALL set err_o to 1 when ACK has lasted AckTimeout cycles with rst_req_i still at 1; the FSM stays in ACK and rst_stat_o stays at 1.
REQ-025 SHALL clear err_o when err_clr_i is 1, except that a timeout on the same edge wins and err_o stays set.
REQ-026 SHALL increment evt_cnt_o by 1 on each IDLE-to-ASSERT transition, saturating at all-ones with no wrap.

Reset
REQ-027 SHALL, on an edge with rst_i sampled 1, force state IDLE, counters to 0, evt_cnt_o to 0, and slv_rst_o, rst_stat_o, busy_o and err_o to 0 from the next cycle.
REQ-028 SHALL abort any in-progress sequence on rst_i, deasserting slv_rst_o immediately.
REQ-029 SHALL ignore rst_req_i while rst_i is 1; after reset, a still-high rst_req_i starts a new event on the first edge with rst_i at 0.

Verification
Use AssertCycles=4, SettleCycles=2, AckTimeout=3 unless stated otherwise.
REQ-030 SHALL cover the basic handshake: rst_req_i rises at cycle 10 and falls 1 cycle after rst_stat_o rises -> slv_rst_o is 1 in cycles 11-14, rst_stat_o is 1 from cycle 17, busy_o returns to 0, and evt_cnt_o=1.
REQ-031 SHALL cover an early drop: rst_req_i is a 1-cycle pulse -> slv_rst_o is still high for 4 cycles, ACK lasts exactly 1 cycle, and err_o stays 0.
REQ-032 SHALL cover an acknowledge timeout: rst_req_i is held high indefinitely -> err_o rises after the 3rd ACK cycle and rst_stat_o stays at 1; err_clr_i then clears err_o; dropping rst_req_i returns the FSM to IDLE.
REQ-033 SHALL cover reset mid-operation: rst_i pulses during ASSERT cycle 2 -> all outputs are 0 the next cycle; a still-high rst_req_i restarts the sequence with evt_cnt_o=1.
REQ-034 SHALL cover counter saturation: with EvtCntWidth=2, run 5 events -> evt_cnt_o reads 1, 2, 3, 3, 3.
REQ-035 SHALL cover zero settle: with SettleCycles=0, rst_stat_o rises in the cycle immediately after the last slv_rst_o=1 cycle.

Source files
------------

// File: rtl/slv_guard_rst_ctrl.sv
// ==[ slv_guard_rst_ctrl | reset sequencer: req/ack handshake driving a guarded subordinate's reset | rev 1.0 ]==
`default_nettype none

module slv_guard_rst_ctrl #(
  parameter int AssertCycles = 16,
  parameter int SettleCycles = 4,
  parameter int AckTimeout   = 8,
  parameter int EvtCntWidth  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rst_req_i,
  output logic                   slv_rst_o,
  output logic                   rst_stat_o,
  output logic                   busy_o,
  output logic                   err_o,
  input  logic                   err_clr_i,
  output logic [EvtCntWidth-1:0] evt_cnt_o
);

  localparam int MAX_A_S = (AssertCycles > SettleCycles) ? AssertCycles : SettleCycles;
  localparam int MAX_CNT = (MAX_A_S > AckTimeout) ? MAX_A_S : AckTimeout;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(AssertCycles - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'((SettleCycles > 0) ? SettleCycles - 1 : 0);
  localparam logic [CNT_W-1:0] ACK_LOAD    = CNT_W'(AckTimeout - 1);
  localparam logic [EvtCntWidth-1:0] EVT_ONE = EvtCntWidth'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ASSERT = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] ACK    = 2'd3;

  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  logic                   timeout;
  logic                   timed_out;
  logic                   slv_rst;
  logic                   rst_stat;
  logic                   busy;
  logic                   err;
  logic [EvtCntWidth-1:0] evt_cnt;

  // cnt holds remaining cycles of the current phase minus one; it stops at zero
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (rst_req_i) begin
          state_nxt = ASSERT;
          cnt_nxt   = ASSERT_LOAD;
        end
      end
      ASSERT: begin
        if (cnt == '0) begin
          if (SettleCycles > 0) begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end else begin
            state_nxt = ACK;
            cnt_nxt   = ACK_LOAD;
          end
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ACK;
          cnt_nxt   = ACK_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ACK: begin
        if (!rst_req_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          // Fire once per ACK visit so err_clr_i can clear the flag while the request is held
          timeout = !timed_out;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      timed_out <= 1'b0;
      slv_rst   <= 1'b0;
      rst_stat  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      timed_out <= (state_nxt == ACK) && (timed_out || timeout);
      slv_rst   <= (state_nxt == ASSERT);
      rst_stat  <= (state_nxt == ACK);
      busy      <= (state_nxt != IDLE);
      if (timeout) begin
        err <= 1'b1;
      end else if (err_clr_i) begin
        err <= 1'b0;
      end
      if ((state == IDLE) && rst_req_i && (evt_cnt != '1)) begin
        evt_cnt <= evt_cnt + EVT_ONE;
      end
    end
  end

  assign slv_rst_o  = slv_rst;
  assign rst_stat_o = rst_stat;
  assign busy_o     = busy;
  assign err_o      = err;
  assign evt_cnt_o  = evt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_slv_guard_rst_ctrl.sv
// ==[ tb_slv_guard_rst_ctrl | bench for slv_guard_rst_ctrl: vector table, corner sequences, random vs model | rev 1.0 ]==
`default_nettype none

module tb_slv_guard_rst_ctrl;

  logic clk = 1'b0;
  logic req = 1'b0;
  logic clr = 1'b0;
  logic rst = 1'b1;

  logic slv0, stat0, busy0, err0;
  logic slv1, stat1, busy1, err1;
  logic slv2, stat2, busy2, err2;
  logic [7:0] evt0;
  logic [1:0] evt1;
  logic [7:0] evt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  slv_guard_rst_ctrl #(.AssertCycles(4), .SettleCycles(2), .AckTimeout(3), .EvtCntWidth(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .rst_req_i(req), .slv_rst_o(slv0), .rst_stat_o(stat0),
    .busy_o(busy0), .err_o(err0), .err_clr_i(clr), .evt_cnt_o(evt0));

  slv_guard_rst_ctrl #(.AssertCycles(4), .SettleCycles(2), .AckTimeout(3), .EvtCntWidth(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .rst_req_i(req), .slv_rst_o(slv1), .rst_stat_o(stat1),
    .busy_o(busy1), .err_o(err1), .err_clr_i(clr), .evt_cnt_o(evt1));

  slv_guard_rst_ctrl #(.AssertCycles(4), .SettleCycles(0), .AckTimeout(3), .EvtCntWidth(8)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .rst_req_i(req), .slv_rst_o(slv2), .rst_stat_o(stat2),
    .busy_o(busy2), .err_o(err2), .err_clr_i(clr), .evt_cnt_o(evt2));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: phase name plus cycles spent in it, evaluated once per clock edge
  localparam int PH_IDLE = 0, PH_ASSERT = 1, PH_SETTLE = 2, PH_ACK = 3;
  typedef struct {
    int phase;
    int age;
    bit err;
    int evt;
  } mstate_t;

  function automatic mstate_t mstep(mstate_t s, bit r, bit c, bit x, int a, int st, int t, int w);
    mstate_t n;
    bit fire;
    n = s;
    fire = 1'b0;
    if (x) begin
      n.phase = PH_IDLE; n.age = 0; n.err = 1'b0; n.evt = 0;
      return n;
    end
    case (s.phase)
      PH_IDLE: if (r) begin
        n.phase = PH_ASSERT; n.age = 1;
        n.evt = (s.evt == (1 << w) - 1) ? s.evt : s.evt + 1;
      end
      PH_ASSERT: if (s.age == a) begin
        n.phase = (st > 0) ? PH_SETTLE : PH_ACK; n.age = 1;
      end else n.age = s.age + 1;
      PH_SETTLE: if (s.age == st) begin
        n.phase = PH_ACK; n.age = 1;
      end else n.age = s.age + 1;
      default: if (!r) begin
        n.phase = PH_IDLE; n.age = 0;
      end else begin
        fire = (s.age == t); n.age = s.age + 1;
      end
    endcase
    n.err = fire ? 1'b1 : (c ? 1'b0 : s.err);
    return n;
  endfunction

  function automatic logic [63:0] mexp(mstate_t s);
    return {28'd0, s.phase == PH_ASSERT, s.phase == PH_ACK, s.phase != PH_IDLE, s.err, 32'(s.evt)};
  endfunction

  mstate_t m0, m1, m2;
  bit armed = 1'b0;

  always @(posedge clk) begin
    m0 <= mstep(m0, req, clr, rst, 4, 2, 3, 8);
    m1 <= mstep(m1, req, clr, rst, 4, 2, 3, 2);
    m2 <= mstep(m2, req, clr, rst, 4, 0, 3, 8);
    if (rst) armed <= 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("model_dut0", {28'd0, slv0, stat0, busy0, err0, 24'd0, evt0}, mexp(m0));
      check("model_dut1", {28'd0, slv1, stat1, busy1, err1, 30'd0, evt1}, mexp(m1));
      check("model_dut2", {28'd0, slv2, stat2, busy2, err2, 24'd0, evt2}, mexp(m2));
    end
  end

  typedef struct {
    bit r, c, x;
    bit slv, stat, busy, err;
    int evt;
  } vec_t;
  vec_t tv[$];

  function automatic void add(bit r, bit c, bit x, bit s, bit k, bit b, bit e, int v);
    vec_t t;
    t.r = r; t.c = c; t.x = x; t.slv = s; t.stat = k; t.busy = b; t.err = e; t.evt = v;
    tv.push_back(t);
  endfunction

  // Each vector's inputs are applied for one cycle; expectations are the outputs after that edge
  task automatic cycle(input bit r, input bit c, input bit x);
    req = r; clr = c; rst = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit rr;
    int n;
    // basic handshake (dut0: assert 4, settle 2, timeout 3)
    add(0,0,1, 0,0,0,0,0);
    add(0,0,0, 0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(1,0,0, 1,0,1,0,1);
    for (int i = 0; i < 2; i++) add(1,0,0, 0,0,1,0,1);
    for (int i = 0; i < 2; i++) add(1,0,0, 0,1,1,0,1);
    for (int i = 0; i < 2; i++) add(0,0,0, 0,0,0,0,1);
    // one-cycle request pulse: full sequence, single ACK cycle
    add(1,0,0, 1,0,1,0,2);
    for (int i = 0; i < 3; i++) add(0,0,0, 1,0,1,0,2);
    for (int i = 0; i < 2; i++) add(0,0,0, 0,0,1,0,2);
    add(0,0,0, 0,1,1,0,2);
    add(0,0,0, 0,0,0,0,2);
    // held request: timeout after third ACK cycle, then clear while still held
    for (int i = 0; i < 4; i++) add(1,0,0, 1,0,1,0,3);
    for (int i = 0; i < 2; i++) add(1,0,0, 0,0,1,0,3);
    for (int i = 0; i < 3; i++) add(1,0,0, 0,1,1,0,3);
    for (int i = 0; i < 2; i++) add(1,0,0, 0,1,1,1,3);
    add(1,1,0, 0,1,1,0,3);
    add(1,0,0, 0,1,1,0,3);
    for (int i = 0; i < 2; i++) add(0,0,0, 0,0,0,0,3);
    // clear on the timeout edge loses; err stays sticky in IDLE until cleared
    for (int i = 0; i < 4; i++) add(1,0,0, 1,0,1,0,4);
    for (int i = 0; i < 2; i++) add(1,0,0, 0,0,1,0,4);
    for (int i = 0; i < 3; i++) add(1,0,0, 0,1,1,0,4);
    add(1,1,0, 0,1,1,1,4);
    add(0,0,0, 0,0,0,1,4);
    add(0,1,0, 0,0,0,0,4);
    // reset during second ASSERT cycle with the request still high
    add(1,0,0, 1,0,1,0,5);
    add(1,0,0, 1,0,1,0,5);
    add(1,0,1, 0,0,0,0,0);
    add(1,0,0, 1,0,1,0,1);
    for (int i = 0; i < 3; i++) add(0,0,0, 1,0,1,0,1);
    for (int i = 0; i < 2; i++) add(0,0,0, 0,0,1,0,1);
    add(0,0,0, 0,1,1,0,1);
    add(0,0,0, 0,0,0,0,1);

    for (int i = 0; i < tv.size(); i++) begin
      cycle(tv[i].r, tv[i].c, tv[i].x);
      check($sformatf("vec%0d_slv", i),  64'(slv0),  64'(tv[i].slv));
      check($sformatf("vec%0d_stat", i), 64'(stat0), 64'(tv[i].stat));
      check($sformatf("vec%0d_busy", i), 64'(busy0), 64'(tv[i].busy));
      check($sformatf("vec%0d_err", i),  64'(err0),  64'(tv[i].err));
      check($sformatf("vec%0d_evt", i),  64'(evt0),  64'(tv[i].evt));
    end

    // zero settle: ACK directly after the fourth reset cycle
    cycle(0,0,1);
    cycle(0,0,0);
    cycle(1,0,0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("zs_assert%0d_slv", i), 64'(slv2), 64'd1);
      check($sformatf("zs_assert%0d_stat", i), 64'(stat2), 64'd0);
      cycle(1,0,0);
    end
    check("zs_ack_slv", 64'(slv2), 64'd0);
    check("zs_ack_stat", 64'(stat2), 64'd1);
    for (int i = 0; i < 3; i++) cycle(0,0,0);

    // event counter saturation on the 2-bit instance
    cycle(0,0,1);
    cycle(0,0,0);
    for (int e = 1; e <= 5; e++) begin
      cycle(1,0,0);
      check($sformatf("sat_evt%0d", e), 64'(evt1), 64'((e < 3) ? e : 3));
      n = 0;
      while (!stat1 && n < 20) begin
        cycle(1,0,0);
        n++;
      end
      check($sformatf("sat_ack_seen%0d", e), 64'(stat1), 64'd1);
      cycle(0,0,0);
      cycle(0,0,0);
    end

    // random traffic, checked every cycle against the reference on all instances
    rr = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) rr = ~rr;
      cycle(rr, $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
    end
    for (int i = 0; i < 4; i++) cycle(0,0,0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
